// File: rtl/qarma_pkg.sv
// Shared widths and types for the QARMA request scheduler slice.
package qarma_pkg;

   localparam int N_BITS   = 128;
   localparam int KEY_BITS = 2 * N_BITS;

   typedef logic [N_BITS-1:0]   blk_t;
   typedef logic [KEY_BITS-1:0] key_t;

   // Requester-index width; stays at one bit even for a single requester.
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/qarma_req_scheduler_if.sv
// Requester, core and response bundle of the QARMA request scheduler.
interface qarma_req_scheduler_if #(
   parameter int N    = qarma_pkg::N_BITS,
   parameter int NREQ = 4
);
   import qarma_pkg::*;

   localparam int IDW = id_w(NREQ);

   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*2*N-1:0] req_k;
   logic [NREQ*N-1:0]   req_p;
   logic [NREQ*N-1:0]   req_t;
   logic [2*N-1:0]      core_k;
   logic [N-1:0]        core_p;
   logic [N-1:0]        core_t;
   logic [N-1:0]        core_c;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [IDW-1:0]      rsp_id;
   logic [N-1:0]        rsp_c;
   logic                busy;

   modport slave (
      input  req_valid, req_k, req_p, req_t, core_c, rsp_ready,
      output req_ready, core_k, core_p, core_t, rsp_valid, rsp_id, rsp_c, busy
   );

   modport master (
      output req_valid, req_k, req_p, req_t, core_c, rsp_ready,
      input  req_ready, core_k, core_p, core_t, rsp_valid, rsp_id, rsp_c, busy
   );

endinterface

// File: rtl/qarma_rsp_fifo.sv
// First-word fall-through response FIFO; rdata is valid whenever empty is low.
module qarma_rsp_fifo
   import qarma_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);

   localparam int AW = id_w(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_MAX);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem_q[rd_ptr_q];

   // Pointer wrap and occupancy update.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   // Control state with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; only entries below count_q are ever read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/qarma_req_scheduler.sv
// Round-robin scheduler sharing one pipelined QARMA core among NREQ requesters.
// Credits cover in-flight plus queued results, so every core result has a FIFO slot.
module qarma_req_scheduler
   import qarma_pkg::*;
#(
   parameter int N          = N_BITS,
   parameter int NREQ       = 4,
   parameter int CORE_LAT   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   qarma_req_scheduler_if.slave  bus
);

   localparam int IDW = id_w(NREQ);
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0]  CREDIT_MAX = CW'(FIFO_DEPTH);
   localparam logic [IDW-1:0] PTR_LAST   = IDW'(NREQ - 1);

   logic [IDW-1:0]                ptr_q, ptr_d;
   logic [CW-1:0]                 credit_q, credit_d;
   logic [2*N-1:0]                last_k_q, last_k_d;
   logic [N-1:0]                  last_p_q, last_p_d;
   logic [N-1:0]                  last_t_q, last_t_d;
   logic [CORE_LAT-1:0]           tag_vld_q, tag_vld_d;
   logic [CORE_LAT-1:0][IDW-1:0]  tag_id_q, tag_id_d;
   logic                          grant, push, pop, fifo_empty, fifo_full;
   logic [IDW-1:0]                gnt_id;
   logic [IDW+N-1:0]              fifo_rdata;
   logic [2*N-1:0]                k_arr [NREQ];
   logic [N-1:0]                  p_arr [NREQ];
   logic [N-1:0]                  t_arr [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign k_arr[g] = bus.req_k[g*2*N +: 2*N];
      assign p_arr[g] = bus.req_p[g*N +: N];
      assign t_arr[g] = bus.req_t[g*N +: N];
   end

   // Round-robin search from the pointer, only while a credit is available.
   always_comb begin
      int             idx;
      logic [IDW-1:0] idx_b;
      grant  = 1'b0;
      gnt_id = '0;
      idx    = 0;
      idx_b  = '0;
      if (rst && (credit_q != '0)) begin
         for (int off = 0; off < NREQ; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_b = IDW'(idx);
            if (!grant && bus.req_valid[idx_b]) begin
               grant  = 1'b1;
               gnt_id = idx_b;
            end
         end
      end
   end

   // One-hot grant and core operand mux; idle cycles replay the last operands.
   always_comb begin
      bus.req_ready = '0;
      bus.core_k    = last_k_q;
      bus.core_p    = last_p_q;
      bus.core_t    = last_t_q;
      if (grant) begin
         bus.req_ready[gnt_id] = 1'b1;
         bus.core_k            = k_arr[gnt_id];
         bus.core_p            = p_arr[gnt_id];
         bus.core_t            = t_arr[gnt_id];
      end
   end

   assign push = tag_vld_q[CORE_LAT-1];
   assign pop  = bus.rsp_valid & bus.rsp_ready;

   // Next pointer, credit, held operands and tag pipe shift.
   always_comb begin
      ptr_d = ptr_q;
      if (grant) ptr_d = (gnt_id == PTR_LAST) ? '0 : gnt_id + 1'b1;
      credit_d  = credit_q + CW'(pop) - CW'(grant);
      last_k_d  = bus.core_k;
      last_p_d  = bus.core_p;
      last_t_d  = bus.core_t;
      tag_vld_d = CORE_LAT'({tag_vld_q, grant});
      tag_id_d  = (CORE_LAT*IDW)'({tag_id_q, gnt_id});
   end

   // Scheduler state with synchronous active-low reset; drops all in-flight tags.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr_q     <= '0;
         credit_q  <= CREDIT_MAX;
         last_k_q  <= '0;
         last_p_q  <= '0;
         last_t_q  <= '0;
         tag_vld_q <= '0;
         tag_id_q  <= '0;
      end else begin
         ptr_q     <= ptr_d;
         credit_q  <= credit_d;
         last_k_q  <= last_k_d;
         last_p_q  <= last_p_d;
         last_t_q  <= last_t_d;
         tag_vld_q <= tag_vld_d;
         tag_id_q  <= tag_id_d;
      end
   end

   qarma_rsp_fifo #(
      .WIDTH (IDW + N),
      .DEPTH (FIFO_DEPTH)
   ) u_rsp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata ({tag_id_q[CORE_LAT-1], bus.core_c}),
      .pop   (pop),
      .rdata (fifo_rdata),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign bus.rsp_valid = rst & ~fifo_empty;
   assign bus.rsp_id    = fifo_rdata[IDW+N-1:N];
   assign bus.rsp_c     = fifo_rdata[N-1:0];
   assign bus.busy      = rst & (credit_q != CREDIT_MAX);

   // Credit must stay in range and a result must always find a free FIFO slot.
   always @(posedge clk) begin
      if (rst) begin
         assert (credit_q <= CREDIT_MAX);
         assert (!(push && fifo_full));
      end
   end

endmodule

// File: tb/tb_qarma_req_scheduler.sv
// Bench for qarma_req_scheduler with a two-stage registered stand-in core.
module tb_qarma_req_scheduler;
   import qarma_pkg::*;

   localparam int NREQ     = 4;
   localparam int CORE_LAT = 2;
   localparam int DEPTH    = 4;
   localparam int IDW      = id_w(NREQ);

   typedef struct packed {
      logic [NREQ-1:0] gnt;
      logic            rv;
      logic [IDW-1:0]  rid;
      blk_t            rc;
      logic            busy;
   } obs_t;

   typedef struct {
      int   id;
      blk_t c;
      int   avail;
   } ent_t;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [NREQ-1:0] req_valid = '0;
   logic            rsp_ready = 1'b0;
   key_t            k_in [NREQ];
   blk_t            p_in [NREQ];
   blk_t            t_in [NREQ];
   blk_t            core_s1, core_c_r;

   obs_t exp_log[$];
   obs_t obs_log[$];
   ent_t mq[$];
   int   m_ptr, m_credit, cyc, n_checks, n_fail;
   logic [NREQ-1:0] last_hs;

   always #5 clk = ~clk;

   qarma_req_scheduler_if #(.N(N_BITS), .NREQ(NREQ)) bus ();

   qarma_req_scheduler #(
      .N(N_BITS), .NREQ(NREQ), .CORE_LAT(CORE_LAT), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.req_valid = req_valid;
   assign bus.rsp_ready = rsp_ready;
   assign bus.core_c    = core_c_r;

   always_comb begin
      bus.req_k = '0;
      bus.req_p = '0;
      bus.req_t = '0;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_k[i*KEY_BITS +: KEY_BITS] = k_in[i];
         bus.req_p[i*N_BITS +: N_BITS]     = p_in[i];
         bus.req_t[i*N_BITS +: N_BITS]     = t_in[i];
      end
   end

   // Keyed mixing function standing in for the cipher; any injective-ish mix exposes routing errors.
   function automatic blk_t mix(input key_t k, input blk_t p, input blk_t t);
      blk_t x;
      x = p ^ k[127:0];
      x = {x[94:0], x[127:95]} + t;
      x = x ^ k[255:128] ^ {t[63:0], t[127:64]};
      return x ^ (x >> 7) ^ 128'h5a5a_1234_0f0f_9876_c3c3_abcd_7e7e_0001;
   endfunction

   function automatic blk_t rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Two registered stages: operands at edge E give core_c after edge E+1.
   always @(posedge clk) begin
      core_s1  <= mix(bus.core_k, bus.core_p, bus.core_t);
      core_c_r <= core_s1;
   end

   // One clock: model prediction and DUT observation are logged at the falling edge.
   task automatic tick();
      obs_t e, o;
      ent_t en;
      int   g, idx;
      @(negedge clk);
      last_hs = req_valid & bus.req_ready;
      if (rst) begin
         g = -1;
         if (m_credit > 0) begin
            for (int off = 0; off < NREQ; off++) begin
               idx = (m_ptr + off) % NREQ;
               if (g < 0 && req_valid[idx]) g = idx;
            end
         end
         e = '0;
         if (g >= 0) e.gnt = NREQ'(1) << g;
         e.busy = (m_credit != DEPTH);
         if (mq.size() > 0 && mq[0].avail <= cyc) begin
            e.rv  = 1'b1;
            e.rid = IDW'(mq[0].id);
            e.rc  = mq[0].c;
         end
         o      = '0;
         o.gnt  = bus.req_ready;
         o.rv   = bus.rsp_valid;
         o.busy = bus.busy;
         if (bus.rsp_valid) begin
            o.rid = bus.rsp_id;
            o.rc  = bus.rsp_c;
         end
         exp_log.push_back(e);
         obs_log.push_back(o);
         if (e.rv && rsp_ready) begin
            en = mq.pop_front();
            m_credit++;
         end
         if (g >= 0) begin
            en.id    = g;
            en.c     = mix(k_in[g], p_in[g], t_in[g]);
            en.avail = cyc + 1 + CORE_LAT;
            mq.push_back(en);
            m_credit--;
            m_ptr = (g + 1) % NREQ;
         end
      end else begin
         m_ptr    = 0;
         m_credit = DEPTH;
         mq.delete();
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic randomize_fields();
      for (int i = 0; i < NREQ; i++) begin
         k_in[i] = {rnd128(), rnd128()};
         p_in[i] = rnd128();
         t_in[i] = rnd128();
      end
   endtask

   task automatic test_reset();
      obs_t e, o;
      int   n;
      rst = 1'b0; req_valid = '1; rsp_ready = 1'b1;
      tick(); tick();
      rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
      tick(); tick();
      n_checks++;
      if (obs_log[0] !== obs_t'(0)) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h required 0", obs_log[0]);
      end
      n = 0;
      while (exp_log.size() > 0) begin
         e = exp_log.pop_front(); o = obs_log.pop_front(); n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL reset cyc%0d: got %h required %h", n, o, e); end
         n++;
      end
   endtask

   task automatic test_single();
      obs_t e, o;
      int   n;
      k_in[0] = '0; p_in[0] = '0; t_in[0] = '0;
      req_valid = 4'b0001; rsp_ready = 1'b0;
      tick();
      req_valid = '0; rsp_ready = 1'b1;
      repeat (5) tick();
      n_checks++;
      if ({obs_log[0].gnt, obs_log[1].gnt} !== 8'b0001_0000) begin
         n_fail++;
         $display("FAIL single_grant: got %b %b required 0001 0000", obs_log[0].gnt, obs_log[1].gnt);
      end
      n_checks++;
      if ({obs_log[2].rv, obs_log[3].rv, obs_log[3].rid, obs_log[4].rv} !== 5'b01000) begin
         n_fail++;
         $display("FAIL single_latency: got rv2=%b rv3=%b id=%0d rv4=%b required 0 1 0 0",
                  obs_log[2].rv, obs_log[3].rv, obs_log[3].rid, obs_log[4].rv);
      end
      n_checks++;
      if (obs_log[3].rc !== mix('0, '0, '0)) begin
         n_fail++;
         $display("FAIL single_data: got %h required %h", obs_log[3].rc, mix('0, '0, '0));
      end
      n = 0;
      while (exp_log.size() > 0) begin
         e = exp_log.pop_front(); o = obs_log.pop_front(); n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL single cyc%0d: got %h required %h", n, o, e); end
         n++;
      end
   endtask

   task automatic test_round_robin();
      obs_t e, o;
      int   n, nr;
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         k_in[i] = {rnd128(), rnd128()};
         p_in[i] = blk_t'(i);
         t_in[i] = ~blk_t'(i);
      end
      req_valid = '1; rsp_ready = 1'b1;
      repeat (12) tick();
      req_valid = '0;
      repeat (6) tick();
      for (int i = 0; i < 12; i++) begin
         n_checks++;
         if (obs_log[i].gnt !== (NREQ'(1) << (i % NREQ))) begin
            n_fail++;
            $display("FAIL rr_grant%0d: got %b required %b", i, obs_log[i].gnt, NREQ'(1) << (i % NREQ));
         end
      end
      nr = 0;
      for (int i = 0; i < obs_log.size(); i++) begin
         if (obs_log[i].rv === 1'b1) begin
            n_checks++;
            if (obs_log[i].rid !== IDW'(nr % NREQ) ||
                obs_log[i].rc !== mix(k_in[nr % NREQ], blk_t'(nr % NREQ), ~blk_t'(nr % NREQ))) begin
               n_fail++;
               $display("FAIL rr_rsp%0d: got id %0d c %h required id %0d", nr, obs_log[i].rid,
                        obs_log[i].rc, nr % NREQ);
            end
            nr++;
         end
      end
      n_checks++;
      if (nr != 12) begin n_fail++; $display("FAIL rr_rsp_count: got %0d required 12", nr); end
      n = 0;
      while (exp_log.size() > 0) begin
         e = exp_log.pop_front(); o = obs_log.pop_front(); n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL rr cyc%0d: got %h required %h", n, o, e); end
         n++;
      end
   endtask

   task automatic test_backpressure();
      obs_t e, o;
      int   n, ng;
      do_reset();
      randomize_fields();
      req_valid = '1; rsp_ready = 1'b0;
      repeat (8) tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      tick();
      req_valid = '0; rsp_ready = 1'b1;
      repeat (8) tick();
      ng = 0;
      for (int i = 0; i < 8; i++) if (obs_log[i].gnt !== '0) ng++;
      n_checks++;
      if (ng != 4 || obs_log[3].gnt !== 4'b1000) begin
         n_fail++;
         $display("FAIL bp_grant_count: got %0d grants required 4", ng);
      end
      n_checks++;
      if (obs_log[7].busy !== 1'b1 || obs_log[7].gnt !== '0) begin
         n_fail++;
         $display("FAIL bp_stalled: got busy %b gnt %b required 1 0000", obs_log[7].busy, obs_log[7].gnt);
      end
      n_checks++;
      if (obs_log[8].rv !== 1'b1 || obs_log[8].gnt !== '0) begin
         n_fail++;
         $display("FAIL credit_corner_pop: got rv %b gnt %b required 1 0000", obs_log[8].rv, obs_log[8].gnt);
      end
      n_checks++;
      if (obs_log[9].gnt !== 4'b0001) begin
         n_fail++;
         $display("FAIL credit_corner_next: got %b required 0001", obs_log[9].gnt);
      end
      n = 0;
      while (exp_log.size() > 0) begin
         e = exp_log.pop_front(); o = obs_log.pop_front(); n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL bp cyc%0d: got %h required %h", n, o, e); end
         n++;
      end
   endtask

   task automatic test_fairness();
      obs_t e, o;
      int   n, j2;
      do_reset();
      randomize_fields();
      rsp_ready = 1'b1;
      req_valid = 4'b0001;
      repeat (3) tick();
      req_valid = 4'b0101;
      repeat (6) tick();
      req_valid = '0;
      repeat (6) tick();
      j2 = -1;
      for (int j = 3; j < 3 + NREQ; j++) if (j2 < 0 && obs_log[j].gnt === 4'b0100) j2 = j;
      n_checks++;
      if (j2 < 0) begin
         n_fail++;
         $display("FAIL fair_wait: got no grant to 2 in %0d cycles required one", NREQ);
      end else begin
         n_checks++;
         if (obs_log[j2+1].gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL fair_ptr: got %b after grant 2 required 0001", obs_log[j2+1].gnt);
         end
      end
      n = 0;
      while (exp_log.size() > 0) begin
         e = exp_log.pop_front(); o = obs_log.pop_front(); n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL fair cyc%0d: got %h required %h", n, o, e); end
         n++;
      end
   endtask

   task automatic test_reset_midop();
      obs_t e, o;
      int   n, nrv;
      blk_t want;
      do_reset();
      randomize_fields();
      req_valid = '1; rsp_ready = 1'b0;
      repeat (4) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
      repeat (6) tick();
      k_in[0] = {rnd128(), rnd128()}; p_in[0] = rnd128(); t_in[0] = rnd128();
      want = mix(k_in[0], p_in[0], t_in[0]);
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      repeat (5) tick();
      n_checks++;
      if (obs_log[4] !== obs_t'(0)) begin
         n_fail++;
         $display("FAIL midop_after_reset: got %h required 0", obs_log[4]);
      end
      nrv = 0;
      for (int i = 4; i < 10; i++) if (obs_log[i].rv !== 1'b0) nrv++;
      n_checks++;
      if (nrv != 0) begin n_fail++; $display("FAIL midop_stale: got %0d stale responses required 0", nrv); end
      n_checks++;
      if (obs_log[10].gnt !== 4'b0001 || obs_log[12].rv !== 1'b0 || obs_log[13].rv !== 1'b1 ||
          obs_log[13].rid !== '0 || obs_log[13].rc !== want) begin
         n_fail++;
         $display("FAIL midop_fresh: got gnt %b rv %b%b id %0d c %h required 0001 01 0 %h",
                  obs_log[10].gnt, obs_log[12].rv, obs_log[13].rv, obs_log[13].rid, obs_log[13].rc, want);
      end
      n = 0;
      while (exp_log.size() > 0) begin
         e = exp_log.pop_front(); o = obs_log.pop_front(); n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL midop cyc%0d: got %h required %h", n, o, e); end
         n++;
      end
   endtask

   task automatic test_random();
      obs_t e, o;
      int   n;
      do_reset();
      randomize_fields();
      last_hs = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || last_hs[i]) begin
               req_valid[i] = ($urandom_range(0, 3) != 0);
               k_in[i] = {rnd128(), rnd128()};
               p_in[i] = rnd128();
               t_in[i] = rnd128();
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      req_valid = '0; rsp_ready = 1'b1;
      repeat (10) tick();
      n = 0;
      while (exp_log.size() > 0) begin
         e = exp_log.pop_front(); o = obs_log.pop_front(); n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL random cyc%0d: got %h required %h", n, o, e); end
         n++;
      end
   endtask

   initial begin
      n_checks = 0; n_fail = 0; cyc = 0;
      m_ptr = 0; m_credit = DEPTH;
      for (int i = 0; i < NREQ; i++) begin
         k_in[i] = '0; p_in[i] = '0; t_in[i] = '0;
      end
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_fairness();
      test_reset_midop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
